// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   requester and the load/store requester of the multi-cycle CPU. One
//   transaction is in flight at a time. It is issued to memory, held for a
//   fixed latency, and then the read data is returned to the requester that
//   won. When both requesters ask in the same IDLE cycle, the winner
//   alternates so that neither requester starves.
//
// Parameters
//   AW       address width
//   DW       data width
//   MEM_LAT  cycles from the mem_en cycle to valid mem_rdata (1..15)
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   if_req/if_addr            fetch request and address, held until if_gnt
//   if_gnt                    1-cycle pulse: the fetch has been issued
//   if_rvalid/if_rdata        1-cycle pulse; fetched word, held until the
//                             next fetch completes
//   d_req/d_we/d_addr/d_wdata data request, held until d_gnt
//   d_gnt                     1-cycle pulse: the data access has been issued
//   d_rvalid/d_rdata          1-cycle pulse; load data, which a write leaves
//                             unchanged
//   busy                      high in every state except IDLE
//   mem_en/mem_we             memory strobe (ISSUE only) and write enable
//   mem_addr/mem_wdata        registered memory address and write data
//   mem_rdata                 memory read data, valid MEM_LAT cycles after
//                             mem_en
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CNT_W   = 4;
  localparam bit          LAT_ONE = (MEM_LAT == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Owner of the transaction in flight and of the most recent grant (1 = data).
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  // Write flag of the transaction in flight; it outlives mem_we, which is
  // cleared when ISSUE ends.
  logic             we_q, we_d;

  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             if_gnt_q, if_gnt_d;
  logic             d_gnt_q, d_gnt_d;
  logic             if_rvalid_q, if_rvalid_d;
  logic             d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;
  logic             busy_q, busy_d;

  logic             any_req_c;
  logic             win_data_c;

  // Round-robin: data wins when fetch is absent, or when fetch had the
  // previous grant.
  assign any_req_c  = if_req | d_req;
  assign win_data_c = d_req & (~if_req | ~last_q);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req_c) state_d = S_ISSUE;
      S_ISSUE: state_d = LAT_ONE ? S_RESP : S_WAIT;
      // The counter holds the cycles left before RESP; at 1 this is the last
      // WAIT cycle.
      S_WAIT:  if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the datapath. They are
  // computed one cycle ahead so every output comes directly from a flop.
  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          owner_d    = win_data_c;
          last_d     = win_data_c;
          // A fetch never writes.
          we_d       = win_data_c & d_we;
          mem_en_d   = 1'b1;
          mem_we_d   = win_data_c & d_we;
          mem_addr_d = win_data_c ? d_addr : if_addr;
          if (win_data_c) mem_wdata_d = d_wdata;
          if_gnt_d   = ~win_data_c;
          d_gnt_d    = win_data_c;
        end
      end
      S_ISSUE: begin
        cnt_d    = CNT_W'(MEM_LAT - 1);
        mem_we_d = 1'b0;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_RESP: begin
        if (owner_q) begin
          d_rvalid_d = 1'b1;
          if (!we_q) d_rdata_d = mem_rdata;
        end else begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Three arbiter instances with MEM_LAT = 2, 1 and 3, each attached to its
//   own latency-pipelined memory. A transaction-level model predicts every
//   output from the timing rules (grant at T+1, busy T+1..T+1+L, rvalid at
//   T+2+L). Directed scenarios add literal expectations at key cycles.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst       [NI];
  logic        if_req    [NI];
  logic [31:0] if_addr   [NI];
  logic        if_gnt    [NI];
  logic        if_rvalid [NI];
  logic [31:0] if_rdata  [NI];
  logic        d_req     [NI];
  logic        d_we      [NI];
  logic [31:0] d_addr    [NI];
  logic [31:0] d_wdata   [NI];
  logic        d_gnt     [NI];
  logic        d_rvalid  [NI];
  logic [31:0] d_rdata   [NI];
  logic        busy      [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  // DUT instances, each with its own memory that returns data L cycles
  // after mem_en. Outside that window it drives a marker value.
  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int unsigned LK = (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    logic [31:0] emem [256];
    logic [31:0] pipe [4];
    logic [3:0]  pv;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LK)) u_dut (
      .clk      (clk),
      .rst      (rst[k]),
      .if_req   (if_req[k]),
      .if_addr  (if_addr[k]),
      .if_gnt   (if_gnt[k]),
      .if_rvalid(if_rvalid[k]),
      .if_rdata (if_rdata[k]),
      .d_req    (d_req[k]),
      .d_we     (d_we[k]),
      .d_addr   (d_addr[k]),
      .d_wdata  (d_wdata[k]),
      .d_gnt    (d_gnt[k]),
      .d_rvalid (d_rvalid[k]),
      .d_rdata  (d_rdata[k]),
      .busy     (busy[k]),
      .mem_en   (mem_en[k]),
      .mem_we   (mem_we[k]),
      .mem_addr (mem_addr[k]),
      .mem_wdata(mem_wdata[k]),
      .mem_rdata(mem_rdata[k])
    );

    initial begin
      for (int i = 0; i < 256; i++) emem[i] = 32'hA500_0000 | 32'(i * 4);
      emem[8] = 32'h8C22_0004;
    end

    always @(posedge clk) begin
      if (mem_en[k] && mem_we[k]) emem[mem_addr[k][9:2]] = mem_wdata[k];
      if (rst[k]) pv <= 4'b0000;
      else        pv <= {pv[2:0], mem_en[k] & ~mem_we[k]};
      pipe[0] <= emem[mem_addr[k][9:2]];
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end

    assign mem_rdata[k] = pv[LK-1] ? pipe[LK-1] : 32'hBADB_AD00;
  end

  // Transaction-level model.
  bit          m_act   [NI];
  int          m_t     [NI];
  bit          m_own_d [NI];
  bit          m_we    [NI];
  bit          m_last_d[NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic [31:0] m_ifrd  [NI];
  logic [31:0] m_drd   [NI];
  logic [31:0] ref_mem [NI][256];

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 256; i++) ref_mem[k][i] = 32'hA500_0000 | 32'(i * 4);
      ref_mem[k][8] = 32'h8C22_0004;
    end
  end

  always @(posedge clk) begin
    int  l;
    bit  idle;
    bit  wd;
    for (int k = 0; k < NI; k++) begin
      l = lat_of(k);
      if (rst[k]) begin
        m_act[k] = 1'b0; m_last_d[k] = 1'b0; m_we[k] = 1'b0;
        m_addr[k] = '0; m_wdata[k] = '0; m_ifrd[k] = '0; m_drd[k] = '0;
      end else begin
        if (m_act[k] && cyc == m_t[k] + 1 + l && !m_we[k]) begin
          if (m_own_d[k]) m_drd[k]  = ref_mem[k][m_addr[k][9:2]];
          else            m_ifrd[k] = ref_mem[k][m_addr[k][9:2]];
        end
        idle = !m_act[k] || (cyc >= m_t[k] + 2 + l);
        if (idle && (if_req[k] || d_req[k])) begin
          wd = d_req[k] && (!if_req[k] || !m_last_d[k]);
          m_act[k] = 1'b1; m_t[k] = cyc; m_own_d[k] = wd; m_last_d[k] = wd;
          m_we[k] = wd && d_we[k];
          m_addr[k] = wd ? d_addr[k] : if_addr[k];
          if (wd) m_wdata[k] = d_wdata[k];
          if (m_we[k]) ref_mem[k][d_addr[k][9:2]] = d_wdata[k];
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%b want=%b", nm, k, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int l;
    bit gn, rv, bz, own;
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        l   = lat_of(k);
        own = m_own_d[k];
        gn  = m_act[k] && (cyc == m_t[k] + 1);
        rv  = m_act[k] && (cyc == m_t[k] + 2 + l);
        bz  = m_act[k] && (cyc >= m_t[k] + 1) && (cyc <= m_t[k] + 1 + l);
        chk1("m_if_gnt", k, if_gnt[k], gn && !own);
        chk1("m_d_gnt", k, d_gnt[k], gn && own);
        chk1("m_mem_en", k, mem_en[k], gn);
        chk1("m_mem_we", k, mem_we[k], gn && m_we[k]);
        chk1("m_busy", k, busy[k], bz);
        chk1("m_if_rvalid", k, if_rvalid[k], rv && !own);
        chk1("m_d_rvalid", k, d_rvalid[k], rv && own);
        chk32("m_mem_addr", k, mem_addr[k], m_addr[k]);
        if (gn && m_we[k]) chk32("m_mem_wdata", k, mem_wdata[k], m_wdata[k]);
        chk32("m_if_rdata", k, if_rdata[k], m_ifrd[k]);
        chk32("m_d_rdata", k, d_rdata[k], m_drd[k]);
      end
    end
  end

  // Advance n cycles; requesters drop their request after seeing the grant.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (if_gnt[k]) if_req[k] = 1'b0;
        if (d_gnt[k])  d_req[k]  = 1'b0;
      end
    end
  endtask

  initial begin
    int g_prev;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    tick(2);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < NI; k++) begin
      chk1("rst_busy", k, busy[k], 1'b0);
      chk1("rst_mem_en", k, mem_en[k], 1'b0);
      chk32("rst_mem_addr", k, mem_addr[k], 32'h0);
      chk32("rst_mem_wdata", k, mem_wdata[k], 32'h0);
      chk32("rst_if_rdata", k, if_rdata[k], 32'h0);
    end

    // 1: fetch read, L=2.
    if_addr[0] = 32'h20; if_req[0] = 1'b1;
    tick(1);
    chk1("t1_gnt", 0, if_gnt[0], 1'b1);
    chk1("t1_mem_en", 0, mem_en[0], 1'b1);
    chk32("t1_mem_addr", 0, mem_addr[0], 32'h20);
    chk1("t1_busy1", 0, busy[0], 1'b1);
    tick(2);
    chk1("t1_busy3", 0, busy[0], 1'b1);
    chk1("t1_rv3", 0, if_rvalid[0], 1'b0);
    tick(1);
    chk1("t1_rvalid", 0, if_rvalid[0], 1'b1);
    chk32("t1_rdata", 0, if_rdata[0], 32'h8C22_0004);
    chk1("t1_busy4", 0, busy[0], 1'b0);

    // 2: data write then read of the same word.
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEAD_BEEF;
    tick(1);
    chk1("t2_gnt", 0, d_gnt[0], 1'b1);
    chk1("t2_we_issue", 0, mem_we[0], 1'b1);
    chk32("t2_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
    tick(1);
    chk1("t2_we_after", 0, mem_we[0], 1'b0);
    tick(2);
    chk1("t2_wr_rvalid", 0, d_rvalid[0], 1'b1);
    chk32("t2_wr_rdata", 0, d_rdata[0], 32'h0);
    d_req[0] = 1'b1; d_we[0] = 1'b0;
    tick(4);
    chk1("t2_rd_rvalid", 0, d_rvalid[0], 1'b1);
    chk32("t2_rd_rdata", 0, d_rdata[0], 32'hDEAD_BEEF);

    // 3: collision after reset, then a second pair while fetch is pending.
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    chk32("t3_rst_addr", 0, mem_addr[0], 32'h0);
    chk32("t3_rst_drdata", 0, d_rdata[0], 32'h0);
    if_addr[0] = 32'h28; if_req[0] = 1'b1;
    d_addr[0] = 32'h104; d_we[0] = 1'b0; d_req[0] = 1'b1;
    tick(1);
    chk1("t3_d_first", 0, d_gnt[0], 1'b1);
    chk1("t3_if_wait", 0, if_gnt[0], 1'b0);
    tick(3);
    chk1("t3_d_rvalid", 0, d_rvalid[0], 1'b1);
    chk32("t3_d_rdata", 0, d_rdata[0], 32'hA500_0104);
    d_addr[0] = 32'h108; d_req[0] = 1'b1;
    tick(1);
    chk1("t3_if_second", 0, if_gnt[0], 1'b1);
    chk1("t3_d_loses", 0, d_gnt[0], 1'b0);
    tick(3);
    chk32("t3_if_rdata", 0, if_rdata[0], 32'hA500_0028);
    tick(1);
    chk1("t3_d_late", 0, d_gnt[0], 1'b1);
    tick(3);
    chk32("t3_d_rdata2", 0, d_rdata[0], 32'hA500_0108);

    // 4: back-to-back fetches, L=1.
    g_prev = 0;
    for (int i = 0; i < 4; i++) begin
      if_addr[1] = 32'h40 + 32'(i * 4); if_req[1] = 1'b1;
      tick(1);
      chk1("t4_gnt", 1, if_gnt[1], 1'b1);
      if (i > 0) chk32("t4_gap", 1, 32'(cyc - g_prev), 32'd3);
      g_prev = cyc;
      tick(2);
      chk1("t4_rvalid", 1, if_rvalid[1], 1'b1);
      chk32("t4_rdata", 1, if_rdata[1], 32'hA500_0040 + 32'(i * 4));
    end

    // 5: reset during WAIT abandons the read, L=3.
    d_addr[2] = 32'h80; d_we[2] = 1'b0; d_req[2] = 1'b1;
    tick(1);
    chk1("t5_gnt", 2, d_gnt[2], 1'b1);
    tick(1);
    rst[2] = 1'b1;
    tick(1);
    rst[2] = 1'b0;
    chk1("t5_busy", 2, busy[2], 1'b0);
    chk1("t5_mem_en", 2, mem_en[2], 1'b0);
    chk32("t5_mem_addr", 2, mem_addr[2], 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk1("t5_no_rvalid", 2, d_rvalid[2], 1'b0);
    end
    chk32("t5_d_rdata", 2, d_rdata[2], 32'h0);
    if_addr[2] = 32'h24; if_req[2] = 1'b1;
    tick(5);
    chk1("t5_if_rvalid", 2, if_rvalid[2], 1'b1);
    chk32("t5_if_rdata", 2, if_rdata[2], 32'hA500_0024);

    // 6: data request changes during a fetch are ignored until IDLE.
    if_addr[2] = 32'h30; if_req[2] = 1'b1;
    tick(2);
    d_req[2] = 1'b1; d_we[2] = 1'b1; d_addr[2] = 32'h300; d_wdata[2] = 32'h1234_5678;
    tick(1);
    d_req[2] = 1'b0; d_addr[2] = 32'h304;
    chk1("t6_no_we", 2, mem_we[2], 1'b0);
    chk32("t6_addr_hold", 2, mem_addr[2], 32'h30);
    tick(1);
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h108;
    tick(1);
    chk1("t6_if_rvalid", 2, if_rvalid[2], 1'b1);
    chk32("t6_if_rdata", 2, if_rdata[2], 32'hA500_0030);
    chk1("t6_no_dgnt", 2, d_gnt[2], 1'b0);
    tick(1);
    chk1("t6_d_gnt", 2, d_gnt[2], 1'b1);
    chk32("t6_mem_addr", 2, mem_addr[2], 32'h108);
    tick(4);
    chk1("t6_d_rvalid", 2, d_rvalid[2], 1'b1);
    chk32("t6_d_rdata", 2, d_rdata[2], 32'hA500_0108);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
